stream_mux_rr: RTL and testbench

//  Parametrised N-channel, WIDTH-bit stream multiplexer with a registered output and valid/ready handshakes.
//  Two selection modes: fixed select (the 2:1 mux generalised) and fair round-robin arbitration.

---
 rtl/stream_mux_rr.sv | 112 +++++++++++
 tb/tb_stream_mux_rr.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a one-entry registered output.
// Channel choice is either a fixed select or fair round-robin starting at rr_ptr.
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

  logic [WIDTH-1:0] chan [NCH];
  logic             fix_hit;
  logic             rr_hit;
  logic [SELW-1:0]  rr_ch;
  logic             grant_vld;
  logic [SELW-1:0]  grant_ch;
  logic             load;
  logic             xfer;
  logic [SELW-1:0]  rr_ptr;

  logic [WIDTH-1:0] data_p1;
  logic [SELW-1:0]  ch_p1;
  logic             vld_p1;

  function automatic logic [SELW-1:0] ptr_after(input logic [SELW-1:0] g);
    logic [SELW:0] n;
    n = {1'b0, g} + (SELW+1)'(1);
    if (n >= NCH_W) n = '0;
    return n[SELW-1:0];
  endfunction

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      chan[k] = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Stage p0: grant decision on current-cycle inputs
  always_comb begin
    fix_hit = 1'b0;
    if ({1'b0, sel} < NCH_W) begin
      fix_hit = in_valid[sel];
    end
  end

  // Scan from the highest offset down so the offset nearest rr_ptr wins.
  always_comb begin
    logic [SELW:0] sum;
    rr_hit = 1'b0;
    rr_ch  = '0;
    sum    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (SELW+1)'(i);
      if (sum >= NCH_W) sum = sum - NCH_W;
      if (in_valid[sum[SELW-1:0]]) begin
        rr_hit = 1'b1;
        rr_ch  = sum[SELW-1:0];
      end
    end
  end

  always_comb begin
    grant_vld = mode ? rr_hit : fix_hit;
    grant_ch  = mode ? rr_ch  : sel;
  end

  assign load = !vld_p1 || out_ready;
  assign xfer = load && grant_vld && !rst;

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[grant_ch] = 1'b1;
    end
  end

  // Stage p1: output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      rr_ptr  <= '0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= chan[grant_ch];
      ch_p1   <= grant_ch;
      if (mode) begin
        rr_ptr <= ptr_after(grant_ch);
      end
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_data  = data_p1;
  assign out_ch    = ch_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a per-cycle reference model plus literal spot checks,
// and a 5-channel instance for out-of-range select.
module tb_stream_mux_rr;

  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode;
  logic [1:0]   sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_ch;
  logic         out_valid;
  logic         out_ready;

  logic         mode5;
  logic [2:0]   sel5;
  logic [39:0]  in_data5;
  logic [4:0]   in_valid5;
  logic [4:0]   in_ready5;
  logic [W-1:0] out_data5;
  logic [2:0]   out_ch5;
  logic         out_valid5;
  logic         out_ready5;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(W), .NCH(N), .SELW(2)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(W), .NCH(5), .SELW(3)) u_dut5 (
    .clk(clk), .rst(rst), .mode(mode5), .sel(sel5),
    .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .out_data(out_data5), .out_ch(out_ch5), .out_valid(out_valid5), .out_ready(out_ready5)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which channel the rules say should win, -1 if none.
  function automatic int pick(input logic md, input int s, input logic [N-1:0] v, input int ptr);
    if (!md) return (s < N && v[s]) ? s : -1;
    for (int i = 0; i < N; i++) begin
      if (v[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  // Reference model state: contents of the output slot and the round-robin pointer.
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  int           m_ch    = 0;
  int           m_ptr   = 0;

  initial begin : compare
    int g;
    logic [N-1:0] exp_rdy;
    forever begin
      @(negedge clk);
      g = pick(mode, int'(sel), in_valid, m_ptr);
      exp_rdy = '0;
      if (!rst && (!m_valid || out_ready) && g >= 0) exp_rdy = N'(1) << g;
      check("model in_ready", 64'(in_ready), 64'(exp_rdy));
      check("model out_valid", 64'(out_valid), 64'(m_valid));
      check("model out_data", 64'(out_data), 64'(m_data));
      check("model out_ch", 64'(out_ch), 64'(m_ch));
      if (rst) begin
        m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
      end else if (exp_rdy != '0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*W +: W];
        m_ch    = g;
        if (mode) m_ptr = (g + 1) % N;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic       md;
    logic [1:0] s;
    logic [3:0] v;
    logic       ordy;
  } vec_t;

  vec_t tbl [16];

  initial begin : stim
    int exp_ch [8];
    tbl = '{
      '{1'b1, 2'd0, 4'b1111, 1'b1}, '{1'b1, 2'd0, 4'b0101, 1'b0}, '{1'b1, 2'd0, 4'b0101, 1'b1},
      '{1'b1, 2'd0, 4'b0101, 1'b1}, '{1'b1, 2'd0, 4'b0000, 1'b1}, '{1'b1, 2'd0, 4'b1001, 1'b1},
      '{1'b0, 2'd3, 4'b0111, 1'b1}, '{1'b0, 2'd3, 4'b1000, 1'b0}, '{1'b0, 2'd1, 4'b0010, 1'b1},
      '{1'b1, 2'd0, 4'b1000, 1'b1}, '{1'b1, 2'd0, 4'b1100, 1'b0}, '{1'b1, 2'd0, 4'b1100, 1'b1},
      '{1'b1, 2'd0, 4'b1111, 1'b1}, '{1'b0, 2'd0, 4'b1110, 1'b1}, '{1'b1, 2'd0, 4'b0011, 1'b1},
      '{1'b1, 2'd0, 4'b0011, 1'b1}
    };
    rst = 1'b1; mode = 1'b1; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = {8'hD3, 8'hA5, 8'h61, 8'h20};
    mode5 = 1'b0; sel5 = 3'd0; in_valid5 = 5'b11111; out_ready5 = 1'b1;
    in_data5 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};

    // reset with every channel requesting
    @(posedge clk); #2;
    check("reset in_ready", 64'(in_ready), 64'h0);
    check("reset out_valid", 64'(out_valid), 64'h0);
    check("reset out_data", 64'(out_data), 64'h0);
    step(); rst = 1'b0;
    #1 check("first rr grant", 64'(in_ready), 64'b0001);

    // round-robin at full throughput
    exp_ch = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      check("rr sequence out_ch", 64'(out_ch), 64'(exp_ch[i]));
      check("rr sequence out_valid", 64'(out_valid), 64'h1);
    end

    // fixed select
    mode = 1'b0; sel = 2'd2;
    #1 check("fixed sel2 in_ready", 64'(in_ready), 64'b0100);
    @(posedge clk); #2;
    check("fixed sel2 out_data", 64'(out_data), 64'hA5);
    check("fixed sel2 out_ch", 64'(out_ch), 64'd2);

    // park rr_ptr at 2, then sparse requests with wrap
    mode = 1'b1; in_valid = 4'b0010;
    step(); in_valid = 4'b1010;
    #1 check("rr skip in_ready", 64'(in_ready), 64'b1000);
    exp_ch[0] = 3; exp_ch[1] = 1; exp_ch[2] = 3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check("rr skip out_ch", 64'(out_ch), 64'(exp_ch[i]));
    end

    // hold 3C under back-pressure, then drain and load together
    in_valid = 4'b0010; in_data = {8'hD3, 8'hA5, 8'h3C, 8'h20};
    step(); in_data = {8'hD3, 8'hA5, 8'h5A, 8'h20}; out_ready = 1'b0;
    #1 check("stall load out_data", 64'(out_data), 64'h3C);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check("stall out_data", 64'(out_data), 64'h3C);
      check("stall out_valid", 64'(out_valid), 64'h1);
      check("stall in_ready", 64'(in_ready), 64'h0);
    end
    out_ready = 1'b1;
    #1 check("drain+load in_ready", 64'(in_ready), 64'b0010);
    @(posedge clk); #2;
    check("drain+load out_valid", 64'(out_valid), 64'h1);
    check("drain+load out_data", 64'(out_data), 64'h5A);

    // reset while holding a stalled word
    out_ready = 1'b0; in_valid = 4'b0000;
    step(); rst = 1'b1; in_valid = 4'b1111;
    @(posedge clk); #2;
    check("mid reset out_valid", 64'(out_valid), 64'h0);
    check("mid reset out_data", 64'(out_data), 64'h0);
    check("mid reset in_ready", 64'(in_ready), 64'h0);
    rst = 1'b0; out_ready = 1'b1;
    #1 check("ptr cleared by reset", 64'(in_ready), 64'b0001);

    // mixed directed traffic, checked by the model
    for (int i = 0; i < 16; i++) begin
      step();
      mode = tbl[i].md; sel = tbl[i].s; in_valid = tbl[i].v; out_ready = tbl[i].ordy;
      in_data = in_data + 32'h01010101;
    end

    // 5-channel instance: select past the last channel never grants
    step(); sel5 = 3'd4;
    #1 check("nch5 sel4 in_ready", 64'(in_ready5), 64'b10000);
    @(posedge clk); #2;
    check("nch5 sel4 out_ch", 64'(out_ch5), 64'd4);
    check("nch5 sel4 out_data", 64'(out_data5), 64'h55);
    for (int s = 5; s < 8; s++) begin
      sel5 = 3'(s);
      #1 check("nch5 sel out of range", 64'(in_ready5), 64'h0);
    end
    @(posedge clk); #2;
    check("nch5 drained", 64'(out_valid5), 64'h0);

    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
